// File: rtl/seq_player_pkg.sv
// rtl/seq_player_pkg.sv - shared state encoding and default pattern table for seq_player
package seq_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_ENTRIES = 8;
    localparam int MAX_SEQ_W   = 64;

    localparam logic [7:0] DEFAULT_PAT [DEF_ENTRIES] = '{
        8'hF7, 8'h01, 8'h95, 8'h55, 8'hAB, 8'hB8, 8'hBB, 8'hBE
    };

    // Zero-extended to MAX_SEQ_W; callers cast down to SEQ_W, which keeps the LSBs.
    function automatic logic [MAX_SEQ_W-1:0] default_entry(input int idx);
        logic [MAX_SEQ_W-1:0] val;
        val = '0;
        if (idx >= 0 && idx < DEF_ENTRIES) begin
            val[7:0] = DEFAULT_PAT[idx[2:0]];
        end
        return val;
    endfunction

endpackage

// File: rtl/seq_table.sv
// rtl/seq_table.sv - pattern table: constant ROM, or writable register file with SEQ_PLAYER_WR_EN
module seq_table
    import seq_player_pkg::*;
#(
    parameter int SEQ_W = 8,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
`ifdef SEQ_PLAYER_WR_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [SEQ_W-1:0] wr_data,
`endif
    input  logic [IDX_W-1:0] rd_idx,
    output logic [SEQ_W-1:0] rd_data
);

`ifdef SEQ_PLAYER_WR_EN
    logic [SEQ_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= SEQ_W'(default_entry(i));
            end
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read returns the pre-write value when a write lands in the same cycle.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_data = mem[rd_idx];
        end
    end
`else
    logic [SEQ_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = SEQ_W'(default_entry(i));
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < DEPTH) begin
            rd_data = rom[rd_idx];
        end
    end
`endif

endmodule

// File: rtl/seq_player.sv
// rtl/seq_player.sv - serial pattern player, MSB first; SEQ_PLAYER_WR_EN adds table write port
module seq_player
    import seq_player_pkg::*;
#(
    parameter int SEQ_W = 8,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [IDX_W-1:0]         index,
    input  logic                     repeat_en,
    input  logic [DIV_W-1:0]         bit_div,
`ifdef SEQ_PLAYER_WR_EN
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_addr,
    input  logic [SEQ_W-1:0]         wr_data,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     ser_out,
    output logic [SEQ_W-1:0]         seq_out,
    output logic [$clog2(SEQ_W)-1:0] bit_idx
);

    localparam int               BIT_W = $clog2(SEQ_W);
    localparam logic [BIT_W-1:0] MSB   = BIT_W'(SEQ_W - 1);

    state_t           state, state_n;
    logic             accept;
    logic             rep_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [SEQ_W-1:0] tbl_data;

    seq_table #(
        .SEQ_W (SEQ_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
`ifdef SEQ_PLAYER_WR_EN
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`endif
        .rd_idx  (index),
        .rd_data (tbl_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = SHIFT;
                    accept  = 1'b1;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cnt == '0 && bit_idx == '0 && !rep_q) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Run parameters are captured once at start so mid-run input changes are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_out <= '0;
            rep_q   <= 1'b0;
            div_q   <= '0;
            cnt     <= '0;
            bit_idx <= MSB;
        end else if (accept) begin
            seq_out <= tbl_data;
            rep_q   <= repeat_en;
            div_q   <= bit_div;
            cnt     <= bit_div;
            bit_idx <= MSB;
        end else if (state == SHIFT) begin
            if (stop) begin
                cnt     <= '0;
                bit_idx <= MSB;
            end else if (cnt == '0) begin
                cnt     <= div_q;
                bit_idx <= (bit_idx == '0) ? MSB : bit_idx - 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign ser_out = (state == SHIFT) ? seq_out[bit_idx] : 1'b0;

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - scoreboard bench for seq_player (default and SEQ_W=12/DEPTH=16 instances)
module tb_seq_player;

    localparam int SEQ_W = 8;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int DIV_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start, stop, repeat_en;
    logic [IDX_W-1:0] index;
    logic [DIV_W-1:0] bit_div;
    logic             busy, done, ser_out;
    logic [SEQ_W-1:0] seq_out;
    logic [2:0]       bit_idx;

    logic             start12, stop12, rep12;
    logic [3:0]       index12;
    logic [DIV_W-1:0] div12;
    logic             busy12, done12, ser12;
    logic [11:0]      seq12;
    logic [3:0]       bit_idx12;

`ifdef SEQ_PLAYER_WR_EN
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [SEQ_W-1:0] wr_data;
    logic             wr_en12;
    logic [3:0]       wr_addr12;
    logic [11:0]      wr_data12;
`endif

    seq_player #(.SEQ_W(SEQ_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .index     (index),
        .repeat_en (repeat_en),
        .bit_div   (bit_div),
`ifdef SEQ_PLAYER_WR_EN
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
`endif
        .busy      (busy),
        .done      (done),
        .ser_out   (ser_out),
        .seq_out   (seq_out),
        .bit_idx   (bit_idx)
    );

    seq_player #(.SEQ_W(12), .DEPTH(16), .DIV_W(DIV_W)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start12),
        .stop      (stop12),
        .index     (index12),
        .repeat_en (rep12),
        .bit_div   (div12),
`ifdef SEQ_PLAYER_WR_EN
        .wr_en     (wr_en12),
        .wr_addr   (wr_addr12),
        .wr_data   (wr_data12),
`endif
        .busy      (busy12),
        .done      (done12),
        .ser_out   (ser12),
        .seq_out   (seq12),
        .bit_idx   (bit_idx12)
    );

    logic [7:0] pat [8] = '{8'hF7, 8'h01, 8'h95, 8'h55, 8'hAB, 8'hB8, 8'hBB, 8'hBE};

    typedef struct {
        logic busy;
        logic done;
        logic ser;
        logic chk_idx;
        int   bidx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic b, input logic d, input logic s, input logic ci, input int bi);
        exp_t e;
        e.busy = b; e.done = d; e.ser = s; e.chk_idx = ci; e.bidx = bi;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic push_oneshot(input logic [7:0] p, input int div);
        for (int b = 7; b >= 0; b--) begin
            for (int k = 0; k <= div; k++) push(1'b1, 1'b0, p[b], 1'b1, b);
        end
        push(1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("busy", busy, e.busy);
                check("done", done, e.done);
                check("ser_out", ser_out, e.ser);
                if (e.chk_idx) check("bit_idx", bit_idx, e.bidx);
            end
        end
    endtask

    task automatic go(input int idx, input int div, input logic rep);
        index     = IDX_W'(idx);
        bit_div   = DIV_W'(div);
        repeat_en = rep;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run12(input int idx, input logic [11:0] exp_pat);
        index12 = 4'(idx);
        start12 = 1'b1;
        @(posedge clk);
        #1 start12 = 1'b0;
        for (int b = 11; b >= 0; b--) begin
            @(negedge clk);
            check("busy12", busy12, 1'b1);
            check("ser12", ser12, exp_pat[b]);
        end
        @(negedge clk);
        check("done12", done12, 1'b1);
        check("seq12", seq12, exp_pat);
    endtask

    initial begin
        start = 0; stop = 0; repeat_en = 0; index = '0; bit_div = '0;
        start12 = 0; stop12 = 0; rep12 = 0; index12 = '0; div12 = '0;
`ifdef SEQ_PLAYER_WR_EN
        wr_en = 0; wr_addr = '0; wr_data = '0;
        wr_en12 = 0; wr_addr12 = '0; wr_data12 = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ser", ser_out, 1'b0);
        check("rst_seq", seq_out, 8'h00);
        check("rst_bit_idx", bit_idx, 3'd7);
        check("rst_bit_idx12", bit_idx12, 4'd11);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // one-shot F7, then a start during DONE must be ignored
        go(0, 0, 1'b0);
        push_oneshot(pat[0], 0);
        drain(9);
        check("seq_f7", seq_out, 8'hF7);
        go(1, 0, 1'b0);
        push_idle(2);
        drain(2);
        check("seq_after_done_start", seq_out, 8'hF7);

        // slow bit period
        go(2, 2, 1'b0);
        push_oneshot(pat[2], 2);
        push_idle(1);
        drain(26);
        check("seq_95", seq_out, 8'h95);

        // start with new inputs mid-run has no effect
        go(1, 1, 1'b0);
        push_oneshot(pat[1], 1);
        push_idle(1);
        drain(5);
        go(6, 5, 1'b1);
        drain(13);
        check("seq_01", seq_out, 8'h01);

        // repeat mode, then stop
        go(3, 0, 1'b1);
        for (int i = 0; i < 20; i++) push(1'b1, 1'b0, pat[3][7 - (i % 8)], 1'b1, 7 - (i % 8));
        drain(20);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        push_idle(3);
        drain(3);

        // stop wins over start in IDLE
        stop = 1'b1;
        go(4, 0, 1'b0);
        stop = 1'b0;
        push_idle(2);
        drain(2);
        check("seq_start_stop", seq_out, 8'h55);

        // back-to-back: start in the cycle after done
        go(4, 0, 1'b0);
        push_oneshot(pat[4], 0);
        push_idle(1);
        drain(10);
        go(5, 0, 1'b0);
        push_oneshot(pat[5], 0);
        push_idle(1);
        drain(10);
        check("seq_b8", seq_out, 8'hB8);

        // asynchronous reset mid-run
        go(6, 3, 1'b0);
        push_oneshot(pat[6], 3);
        drain(10);
        sb.delete();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_ser", ser_out, 1'b0);
        check("arst_seq", seq_out, 8'h00);
        check("arst_bit_idx", bit_idx, 3'd7);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_idle(2);
        drain(2);
        go(7, 0, 1'b0);
        push_oneshot(pat[7], 0);
        push_idle(1);
        drain(10);
        check("seq_be", seq_out, 8'hBE);

`ifdef SEQ_PLAYER_WR_EN
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        @(posedge clk);
        #1 wr_en = 1'b0;
        go(5, 0, 1'b0);
        push_oneshot(8'h3C, 0);
        push_idle(1);
        drain(10);
        check("wr_seq_3c", seq_out, 8'h3C);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h00;
        go(5, 0, 1'b0);
        wr_en = 1'b0;
        push_oneshot(8'h3C, 0);
        push_idle(1);
        drain(10);
        check("wr_same_cycle_old", seq_out, 8'h3C);
        go(5, 0, 1'b0);
        push_oneshot(8'h00, 0);
        push_idle(1);
        drain(10);
        check("wr_seq_00", seq_out, 8'h00);
`endif

        // wider/deeper instance: index 1 -> 001, index 10 -> zeros
        run12(1, 12'h001);
        @(negedge clk);
        run12(10, 12'h000);

        if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
